// File: rtl/pucch_cyclic_shift.sv
// pucch_cyclic_shift: per-symbol PUCCH cyclic-shift index (m0 + m_cs + n_cs(l)) mod 12 from upstream Gold-sequence bytes.
// Optional start-time range checking is enabled by defining PUCCH_CS_RANGE_CHECK_EN.
module pucch_cyclic_shift #(
  parameter int NSYMB = 14
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_start,
  input  logic [3:0] i_m0,
  input  logic [3:0] i_mcs,
  input  logic [3:0] i_start_symbol,
  input  logic [3:0] i_num_symbols,
  input  logic       i_cseq_gen_done,
  input  logic [7:0] i_cseq_byte,
  input  logic       i_cseq_valid,
  output logic       o_cseq_get,
  output logic [3:0] o_alpha_idx,
  output logic [3:0] o_symbol,
  output logic       o_valid,
  input  logic       i_ready,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_err
);
  typedef enum logic [2:0] {IDLE, WAITGEN, REQ, WAITB, OUT, DONE} state_t;
  state_t     state_q, state_d;
  logic [3:0] m0_q, m0_d, mcs_q, mcs_d, start_q, start_d, alpha_q, alpha_d, sym_q, sym_d;
  logic [4:0] k_q, k_d, end_q, end_d;
  logic       err_q, err_d;
  logic       bad;
  logic [8:0] sum;
  logic [3:0] alpha_mod;
`ifdef PUCCH_CS_RANGE_CHECK_EN
  assign bad = (i_m0 > 4'd11) || (i_mcs > 4'd11) || (i_num_symbols == 4'd0) ||
               (({1'b0, i_start_symbol} + {1'b0, i_num_symbols}) > 5'(NSYMB));
`else
  assign bad = 1'b0;
`endif
  assign sum       = {5'd0, m0_q} + {5'd0, mcs_q} + {1'b0, i_cseq_byte};
  assign alpha_mod = 4'(sum % 9'd12);
  // next-state: slot sequencing, byte skipping before the first PUCCH symbol, output capture
  always_comb begin
    state_d = state_q;
    m0_d    = m0_q;
    mcs_d   = mcs_q;
    start_d = start_q;
    end_d   = end_q;
    k_d     = k_q;
    alpha_d = alpha_q;
    sym_d   = sym_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (i_start) begin
        err_d = bad;
        if (!bad) begin
          m0_d    = i_m0;
          mcs_d   = i_mcs;
          start_d = i_start_symbol;
          end_d   = {1'b0, i_start_symbol} + {1'b0, i_num_symbols};
          k_d     = 5'd0;
          state_d = WAITGEN;
        end
      end
      WAITGEN: state_d = i_cseq_gen_done ? REQ : WAITGEN;
      REQ:     state_d = WAITB;
      WAITB: if (i_cseq_valid) begin
        if (k_q < {1'b0, start_q}) begin
          k_d     = k_q + 5'd1;
          state_d = REQ;
        end else begin
          alpha_d = alpha_mod;
          sym_d   = k_q[3:0];
          state_d = OUT;
        end
      end
      OUT: if (i_ready) begin
        k_d     = k_q + 5'd1;
        state_d = (k_q + 5'd1 >= end_q) ? DONE : REQ;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset abandons any partial slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m0_q    <= '0;
      mcs_q   <= '0;
      start_q <= '0;
      end_q   <= '0;
      k_q     <= '0;
      alpha_q <= '0;
      sym_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      m0_q    <= m0_d;
      mcs_q   <= mcs_d;
      start_q <= start_d;
      end_q   <= end_d;
      k_q     <= k_d;
      alpha_q <= alpha_d;
      sym_q   <= sym_d;
      err_q   <= err_d;
    end
  end
  assign o_cseq_get  = state_q == REQ;
  assign o_valid     = state_q == OUT;
  assign o_done      = state_q == DONE;
  assign o_busy      = (state_q != IDLE) && (state_q != DONE);
  assign o_alpha_idx = alpha_q;
  assign o_symbol    = sym_q;
  assign o_err       = err_q;
endmodule

// File: tb/tb_pucch_cyclic_shift.sv
// tb_pucch_cyclic_shift: table-driven scoreboard bench with a stand-in upstream byte source.
module tb_pucch_cyclic_shift;
  logic       clk = 1'b0, rst = 1'b1, i_start = 1'b0;
  logic [3:0] i_m0 = '0, i_mcs = '0, i_start_symbol = '0, i_num_symbols = '0;
  logic       i_cseq_gen_done = 1'b0, i_cseq_valid = 1'b0, i_ready = 1'b0;
  logic [7:0] i_cseq_byte = '0;
  logic       o_cseq_get, o_valid, o_busy, o_done, o_err;
  logic [3:0] o_alpha_idx, o_symbol;

  always #5 clk = ~clk;

  pucch_cyclic_shift dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_m0(i_m0), .i_mcs(i_mcs),
    .i_start_symbol(i_start_symbol), .i_num_symbols(i_num_symbols),
    .i_cseq_gen_done(i_cseq_gen_done), .i_cseq_byte(i_cseq_byte), .i_cseq_valid(i_cseq_valid),
    .o_cseq_get(o_cseq_get), .o_alpha_idx(o_alpha_idx), .o_symbol(o_symbol), .o_valid(o_valid),
    .i_ready(i_ready), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  typedef struct {int m0; int mcs; int st; int num; int hold; int ngets;} vec_t;
  typedef struct {int l; int a;} exp_t;

  // alpha for n_id=512, n_slot=3 with m0=m_cs=0; upstream bytes are chosen congruent to these mod 12
  int   alpha_ref[14] = '{11, 11, 7, 6, 0, 2, 3, 6, 10, 5, 5, 1, 8, 5};
  exp_t exp_q[$];
  int   tests = 0, fails = 0;
  int   hold = 0, hcnt = 0, pend = 0, bidx = 0, gets = 0;
  localparam int LAT = 2;

  function automatic void chk(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endfunction

  // upstream: answers each request LAT cycles later with the next byte of the slot
  always @(posedge clk) begin
    #1;
    i_cseq_valid = 1'b0;
    if (!o_busy) begin
      pend = 0;
      bidx = 0;
    end else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        i_cseq_valid = 1'b1;
        i_cseq_byte  = 8'(alpha_ref[bidx % 14] + 12 * ((bidx * 5 + 3) % 21));
        bidx++;
      end
    end
    if (o_cseq_get) begin
      chk("one_outstanding", pend, 0);
      pend = LAT;
      gets++;
    end
  end

  // downstream: withholds ready for 'hold' cycles of each valid
  always @(posedge clk) begin
    #1;
    if (o_valid) begin
      i_ready = (hcnt >= hold);
      hcnt++;
    end else begin
      i_ready = 1'b0;
      hcnt    = 0;
    end
  end

  // monitor: scoreboard pops on handshake, stability while stalled
  logic       pv = 1'b0, pr = 1'b0;
  logic [3:0] pa = '0, ps = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (pv && !pr) begin
        chk("hold_valid", int'(o_valid), 1);
        chk("hold_alpha", int'(o_alpha_idx), int'(pa));
        chk("hold_symbol", int'(o_symbol), int'(ps));
      end
      if (o_valid && i_ready) begin
        chk("output_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("symbol", int'(o_symbol), e.l);
          chk("alpha", int'(o_alpha_idx), e.a);
        end
      end
      pv = o_valid;
      pr = i_ready;
      pa = o_alpha_idx;
      ps = o_symbol;
    end else pv = 1'b0;
  end

  task automatic push_exp(int m0, int mcs, int st, int num);
    for (int l = st; l < st + num; l++) exp_q.push_back('{l, (alpha_ref[l] + m0 + mcs) % 12});
  endtask

  task automatic pulse_start(int m0, int mcs, int st, int num);
    @(posedge clk); #1;
    i_start = 1'b1;
    i_m0 = 4'(m0);
    i_mcs = 4'(mcs);
    i_start_symbol = 4'(st);
    i_num_symbols = 4'(num);
    @(posedge clk); #1;
    i_start = 1'b0;
    i_m0 = 4'hF;
    i_mcs = 4'hF;
    i_start_symbol = 4'h0;
    i_num_symbols = 4'hF;
  endtask

  task automatic wait_done(string name);
    int n = 0;
    while (n < 3000) begin
      @(negedge clk);
      if (o_done) break;
      n++;
    end
    chk({name, "_done_seen"}, int'(o_done), 1);
    chk({name, "_busy_low_at_done"}, int'(o_busy), 0);
  endtask

  task automatic run_vec(vec_t v);
    int g0 = gets;
    hold = v.hold;
    push_exp(v.m0, v.mcs, v.st, v.num);
    pulse_start(v.m0, v.mcs, v.st, v.num);
    chk("busy_rise", int'(o_busy), 1);
    wait_done("vec");
    chk("get_count", gets - g0, v.ngets);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int   g, n;
    vt[0] = '{0, 0, 0, 14, 0, 14};
    vt[1] = '{3, 6, 10, 4, 0, 14};
    vt[2] = '{3, 6, 10, 4, 5, 14};
    vt[3] = '{11, 11, 5, 3, 1, 8};
    vt[4] = '{7, 2, 13, 1, 0, 14};
    vt[5] = '{0, 5, 0, 1, 2, 1};
    repeat (3) @(posedge clk);
    #1;
    chk("rst_get", int'(o_cseq_get), 0);
    chk("rst_alpha", int'(o_alpha_idx), 0);
    chk("rst_symbol", int'(o_symbol), 0);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_done), 0);
    chk("rst_err", int'(o_err), 0);
    rst = 1'b0;
    i_cseq_gen_done = 1'b1;
    for (int i = 0; i < 6; i++) run_vec(vt[i]);

    i_cseq_gen_done = 1'b0;
    hold = 0;
    g = gets;
    push_exp(2, 1, 12, 2);
    pulse_start(2, 1, 12, 2);
    pulse_start(5, 5, 0, 14);
    repeat (8) @(posedge clk);
    #1;
    chk("no_get_before_gen_done", gets - g, 0);
    chk("busy_waiting_gen", int'(o_busy), 1);
    i_cseq_gen_done = 1'b1;
    wait_done("late_gen");
    chk("late_gen_gets", gets - g, 14);
    chk("late_gen_queue", exp_q.size(), 0);

    hold = 1000;
    pulse_start(4, 4, 3, 2);
    n = 0;
    while (!o_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_out", int'(o_valid), 1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", int'(o_valid), 0);
    chk("arst_busy", int'(o_busy), 0);
    chk("arst_alpha", int'(o_alpha_idx), 0);
    chk("arst_symbol", int'(o_symbol), 0);
    chk("arst_get", int'(o_cseq_get), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    hold = 0;
    run_vec(vt[1]);

`ifdef PUCCH_CS_RANGE_CHECK_EN
    g = gets;
    pulse_start(12, 0, 0, 14);
    chk("err_m0", int'(o_err), 1);
    chk("err_m0_busy", int'(o_busy), 0);
    @(posedge clk); #1;
    chk("err_one_cycle", int'(o_err), 0);
    pulse_start(0, 0, 12, 4);
    chk("err_range", int'(o_err), 1);
    chk("err_range_busy", int'(o_busy), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("err_no_get", gets - g, 0);
    chk("err_no_busy", int'(o_busy), 0);
`else
    push_exp(12, 11, 13, 1);
    pulse_start(12, 11, 13, 1);
    chk("no_err_unchecked", int'(o_err), 0);
    wait_done("unchecked");
    chk("unchecked_queue", exp_q.size(), 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
